pwm_avmm_agent: RTL and testbench
=================================

// Module: pwm_avmm_agent
// PURPOSE
//  Avalon-MM agent PWM generator: the responder for the PID loop's PWM write port.
//  Holds duty/period in double-buffered registers; applied at period wrap.
//  Drives one PWM pin; reads back config and live status over the same port.
// PARAMETERS
//  ADDR_WIDTH   16       avs_address width
//  BASE_ADDR    16'h0000 word address of register 0; regs at BASE_ADDR+0..+3
//  DUTY_WIDTH   12       duty/period/counter width; max value 2**DUTY_WIDTH-1
//  PERIOD_INIT  4095     reset period (counter terminal value)
//  ENABLE_INIT  1        reset value of CTRL.enable
// PORTS
//  clk                in   1           system clock
//  reset_n            in   1           asynchronous active-low reset
//  avs_address        in   ADDR_WIDTH  word address
//  avs_write          in   1           write request
//  avs_writedata      in   32          write data
//  avs_read           in   1           read request
//  avs_readdata       out  32          read data, valid with avs_readdatavalid
//  avs_readdatavalid  out  1           one-cycle read response strobe
//  avs_waitrequest    out  1           stall; combinational
//  pwm_out            out  1           PWM output, registered
//  period_tick        out  1           one-cycle pulse on counter wrap, registered
//  irq                out  1           interrupt (only with PWM_IRQ_EN)
// BEHAVIOUR
//  Reset: readdata 0, readdatavalid 0, pwm_out 0, period_tick 0, irq 0; counter 0;
//   duty_act/duty_sh 0, period_act/period_sh PERIOD_INIT, pending flags 0,
//   CTRL={polarity 0, enable ENABLE_INIT}. Reset mid-anything aborts it, no residue.
//  Map (offset = address-BASE_ADDR): 0 DUTY, 1 PERIOD, 2 CTRL[1:0]={polarity,enable},
//   3 STATUS RO {counter[31:16], 13'b0, irq_flag[2], period_pend[1], duty_pend[0]}.
//   Off-map: write accepted and ignored; read returns 0. Writes to 3 ignored (no IRQ).
//  Write DUTY/PERIOD: value = min(writedata unsigned, 2**DUTY_WIDTH-1) into shadow;
//   pending set. Accepted when waitrequest low.
//  avs_waitrequest = avs_write & target-reg pending & ~apply_now. Reads never stall.
//  apply_now = (enable & counter==period_act) | ~enable. On apply_now each pending
//   shadow copies to active and clears pending; a write accepted in the same cycle
//   lands in shadow and leaves pending set (applies at next wrap).
//  Read: latency 1; readdata/readdatavalid registered; readdatavalid 1 cycle then 0.
//   Read+write same cycle: read returns pre-write value.
//  Counter: enable=1 counts 0..period_act, wraps to 0; period_tick in cycle after wrap.
//   period_act=0: tick every cycle. enable=0: counter held 0, no ticks.
//  pwm_out (next) = enable ? ((counter<duty_act) ^ polarity) : polarity.
//   duty_act=0: constant inactive; duty_act>period_act: constant active.
//  Disable mid-period: counter 0 next cycle, pending shadows applied immediately.
//  Enable 0->1: count starts at 0; first pwm_out edge one cycle later.
// CONFIGURATION
//  PWM_IRQ_EN defined: irq port present; CTRL[2]=irq_mask; irq_flag set on each wrap,
//   write STATUS bit2=1 clears (set wins if same cycle); irq = flag & mask, registered.
//  PWM_IRQ_EN undefined: no irq port; CTRL[2] reserved reads 0; STATUS[2] reads 0.
// TESTING
//  1 reset, PERIOD=9, write DUTY=3 -> pending until wrap, then pwm_out high 3 of 10 cyc.
//  2 DUTY=5 then DUTY=7 mid-period -> second write waitrequest high until wrap;
//    accepted at wrap, 5 used for one period, 7 thereafter.
//  3 DUTY=0x0001_2345 -> stored 4095; PERIOD=9 -> pwm_out constant high; DUTY=0 -> low.
//  4 read offset 3 -> readdatavalid exactly 1 cycle after read, counter in [31:16];
//    read BASE_ADDR+7 -> 0.
//  5 CTRL=2'b11, then CTRL=2'b10 mid-period -> pwm_out inverted, then held 1, counter 0.
//  6 PWM_IRQ_EN, mask=1 -> irq rises after wrap; W1C STATUS bit2 -> irq 0; reset_n low
//    mid-period -> all outputs reset values immediately.

Source files
------------

// File: rtl/pwm_avmm_if.sv
// pwm_avmm_if: Avalon-MM bus bundle between the PID loop (master) and the PWM agent (slave)
//   avs_address, avs_write, avs_writedata, avs_read       master -> agent
//   avs_readdata, avs_readdatavalid, avs_waitrequest      agent -> master
interface pwm_avmm_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] avs_address;
   logic                  avs_write;
   logic [31:0]           avs_writedata;
   logic                  avs_read;
   logic [31:0]           avs_readdata;
   logic                  avs_readdatavalid;
   logic                  avs_waitrequest;
   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata, avs_readdatavalid, avs_waitrequest
   );
   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata, avs_readdatavalid, avs_waitrequest
   );
endinterface

// File: rtl/pwm_avmm_agent.sv
// pwm_avmm_agent: Avalon-MM agent PWM generator with double-buffered duty/period
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   avs          pwm_avmm_if.slave register port: 0 DUTY, 1 PERIOD, 2 CTRL, 3 STATUS
//   pwm_out      registered PWM pin
//   period_tick  registered one-cycle pulse in the cycle after each counter wrap
//   irq          registered interrupt, present only when PWM_IRQ_EN is defined
module pwm_avmm_agent #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    DUTY_WIDTH  = 12,
   parameter int                    PERIOD_INIT = 4095,
   parameter bit                    ENABLE_INIT = 1'b1
) (
   input  logic      clk,
   input  logic      reset_n,
   pwm_avmm_if.slave avs,
   output logic      pwm_out,
   output logic      period_tick
`ifdef PWM_IRQ_EN
   ,
   output logic      irq
`endif
);
   localparam logic [DUTY_WIDTH-1:0] MAX_VAL = '1;
   logic [ADDR_WIDTH-1:0] offset;
   logic [DUTY_WIDTH-1:0] counter, duty_act, duty_sh, period_act, period_sh, wr_val;
   logic                  duty_pend, period_pend, enable, polarity, irq_mask, irq_flag;
   logic                  sel_duty, sel_period, sel_ctrl, sel_status;
   logic                  wrap, apply_now, stall, wr_acc, wr_duty, wr_period, wr_ctrl, en_next;
   logic [31:0]           rd_mux;
   assign offset     = avs.avs_address - BASE_ADDR;
   assign sel_duty   = offset == ADDR_WIDTH'(0);
   assign sel_period = offset == ADDR_WIDTH'(1);
   assign sel_ctrl   = offset == ADDR_WIDTH'(2);
   assign sel_status = offset == ADDR_WIDTH'(3);
   assign wr_val     = (avs.avs_writedata > 32'(MAX_VAL)) ? MAX_VAL : avs.avs_writedata[DUTY_WIDTH-1:0];
   assign wrap       = enable & (counter == period_act);
   // While disabled there is no period to protect, so shadows pass straight through.
   assign apply_now  = wrap | ~enable;
   // Only a second write to a still-pending shadow stalls; it is released in the apply cycle.
   assign stall      = avs.avs_write & ((sel_duty & duty_pend) | (sel_period & period_pend)) & ~apply_now;
   assign avs.avs_waitrequest = stall;
   assign wr_acc     = avs.avs_write & ~stall;
   assign wr_duty    = wr_acc & sel_duty;
   assign wr_period  = wr_acc & sel_period;
   assign wr_ctrl    = wr_acc & sel_ctrl;
   assign en_next    = wr_ctrl ? avs.avs_writedata[0] : enable;
   assign rd_mux     = sel_duty   ? 32'(duty_sh) :
                       sel_period ? 32'(period_sh) :
                       sel_ctrl   ? {29'd0, irq_mask, polarity, enable} :
                       sel_status ? {16'(counter), 13'd0, irq_flag, period_pend, duty_pend} : 32'd0;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter               <= '0;
         duty_act              <= '0;
         duty_sh               <= '0;
         period_act            <= DUTY_WIDTH'(PERIOD_INIT);
         period_sh             <= DUTY_WIDTH'(PERIOD_INIT);
         duty_pend             <= 1'b0;
         period_pend           <= 1'b0;
         enable                <= ENABLE_INIT;
         polarity              <= 1'b0;
         pwm_out               <= 1'b0;
         period_tick           <= 1'b0;
         avs.avs_readdata      <= '0;
         avs.avs_readdatavalid <= 1'b0;
      end else begin
         // Counter restarts from 0 on wrap, and is held at 0 from the cycle a disable lands.
         counter               <= (enable & en_next & ~wrap) ? counter + 1'b1 : '0;
         period_tick           <= wrap;
         pwm_out               <= enable ? ((counter < duty_act) ^ polarity) : polarity;
         if (apply_now & duty_pend) duty_act <= duty_sh;
         if (apply_now & period_pend) period_act <= period_sh;
         if (wr_duty) duty_sh <= wr_val;
         if (wr_period) period_sh <= wr_val;
         // A write landing in the apply cycle keeps its pending flag for the next wrap.
         duty_pend             <= wr_duty | (duty_pend & ~apply_now);
         period_pend           <= wr_period | (period_pend & ~apply_now);
         if (wr_ctrl) {polarity, enable} <= avs.avs_writedata[1:0];
         avs.avs_readdatavalid <= avs.avs_read;
         if (avs.avs_read) avs.avs_readdata <= rd_mux;
      end
   end
`ifdef PWM_IRQ_EN
   logic wr_status;
   assign wr_status = wr_acc & sel_status;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= 1'b0;
         irq_flag <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (wr_ctrl) irq_mask <= avs.avs_writedata[2];
         // Set beats a simultaneous write-one-to-clear.
         irq_flag <= wrap | (irq_flag & ~(wr_status & avs.avs_writedata[2]));
         irq      <= irq_flag & irq_mask;
      end
   end
`else
   assign irq_mask = 1'b0;
   assign irq_flag = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_avmm_agent.sv
// tb_pwm_avmm_agent: randomized scoreboard bench for pwm_avmm_agent
`timescale 1ns/1ps
module tb_pwm_avmm_agent;
   localparam int BASE = 16'h0040;
   localparam int MAXV = 4095;
`ifdef PWM_IRQ_EN
   localparam logic [31:0] CTRL_MASK = 32'h7;
`else
   localparam logic [31:0] CTRL_MASK = 32'h3;
`endif
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic pwm_out, period_tick;
`ifdef PWM_IRQ_EN
   logic irq;
`endif
   pwm_avmm_if #(.ADDR_WIDTH(16)) bus ();
   pwm_avmm_agent #(
      .ADDR_WIDTH(16), .BASE_ADDR(16'h0040), .DUTY_WIDTH(12), .PERIOD_INIT(4095), .ENABLE_INIT(1'b1)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .avs(bus),
      .pwm_out(pwm_out),
      .period_tick(period_tick)
`ifdef PWM_IRQ_EN
      ,
      .irq(irq)
`endif
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_checks = 0;
   int n_fail = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // Reference model: register contents as a master would see them, plus per-window expectations.
   logic [31:0] m_duty = 0, m_period = MAXV, m_ctrl = 1;
   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v > 32'(MAXV)) ? 32'(MAXV) : v;
   endfunction
   function automatic int high_count(input logic [31:0] duty, input int len);
      return (duty < 32'(len)) ? int'(duty) : len;
   endfunction
   typedef struct { logic [31:0] exp; logic [31:0] mask; int cyc; int off; } rd_t;
   typedef struct { int idx; int len; int high; } win_t;
   rd_t  rdq[$];
   win_t winq[$];
   int   win_idx = 0;
   task automatic bus_write(input int off, input logic [31:0] data, output int stalls);
      bus.avs_address   = 16'(BASE + off);
      bus.avs_writedata = data;
      bus.avs_write     = 1'b1;
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!bus.avs_waitrequest) break;
         stalls++;
         if (stalls > 10000) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: offset %0d still stalled after %0d cycles", off, stalls);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.avs_write = 1'b0;
      if (off == 0) m_duty = sat(data);
      else if (off == 1) m_period = sat(data);
      else if (off == 2) m_ctrl = data & CTRL_MASK;
   endtask
   task automatic wr(input int off, input logic [31:0] data);
      int s;
      bus_write(off, data, s);
   endtask
   task automatic rd(input int off, input logic [31:0] exp, input logic [31:0] mask);
      bus.avs_address = 16'(BASE + off);
      bus.avs_read    = 1'b1;
      rdq.push_back('{exp & mask, mask, cyc, off});
      @(posedge clk);
      #1;
      bus.avs_read = 1'b0;
   endtask
   task automatic wait_tick();
      int w = win_idx;
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk);
         #1;
         if (win_idx != w) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: no period_tick within 6000 cycles");
   endtask
   task automatic drain(input int target);
      for (int i = 0; i < 40 && win_idx <= target; i++) wait_tick();
   endtask
   // Read monitor: every response must match the oldest outstanding read, exactly one cycle later.
   initial forever begin
      @(negedge clk);
      if (reset_n && bus.avs_readdatavalid) begin
         if (rdq.size() == 0) check("rd_unexpected_valid", 32'(bus.avs_readdatavalid), 32'd0);
         else begin
            rd_t e;
            e = rdq.pop_front();
            check("rd_latency", 32'(cyc - e.cyc), 32'd1);
            check($sformatf("rd_off%0d", e.off), bus.avs_readdata & e.mask, e.exp);
         end
      end
   end
   // Window monitor: a window runs from the cycle after one tick through the next tick.
   initial begin
      int acc = 0;
      int len = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            acc = 0;
            len = 0;
         end else begin
            len++;
            acc += int'(pwm_out);
            if (period_tick) begin
               while (winq.size() > 0 && winq[0].idx < win_idx) begin
                  check("win_missed", 32'(winq[0].idx), 32'(win_idx));
                  void'(winq.pop_front());
               end
               if (winq.size() > 0 && winq[0].idx == win_idx) begin
                  check("win_len", 32'(len), 32'(winq[0].len));
                  check("win_high", 32'(acc), 32'(winq[0].high));
                  void'(winq.pop_front());
               end
               win_idx++;
               acc = 0;
               len = 0;
            end
         end
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      int s, n, p;
      logic [31:0] d, ds;
      bus.avs_address   = '0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = '0;
      bus.avs_read      = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_tick", 32'(period_tick), 32'd0);
      check("rst_rdvalid", 32'(bus.avs_readdatavalid), 32'd0);
      check("rst_rdata", bus.avs_readdata, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      rd(0, m_duty, '1);
      rd(1, m_period, '1);
      rd(2, m_ctrl, '1);
      // Writes sit pending until the 4095 wrap, then DUTY=3 of PERIOD=9.
      wr(1, 9);
      wr(0, 3);
      rd(3, 32'h3, 32'h3);
      wait_tick();
      n = win_idx;
      winq.push_back('{n, 10, 3});
      winq.push_back('{n + 1, 10, 3});
      rd(3, 32'h0001_0000, 32'hFFFF_0003);
      rd(0, m_duty, '1);
      rd(1, m_period, '1);
      rd(7, 32'd0, '1);
      drain(n + 1);
      // Second write to a pending DUTY stalls until the wrap.
      n = win_idx;
      wr(0, 5);
      bus_write(0, 7, s);
      check("dup_write_stalled", 32'(s >= 1 && s <= 9), 32'd1);
      winq.push_back('{n + 1, 10, 5});
      winq.push_back('{n + 2, 10, 7});
      rd(0, m_duty, '1);
      drain(n + 2);
      // Saturation and the all-high / all-low extremes.
      n = win_idx;
      wr(0, 32'h0001_2345);
      winq.push_back('{n + 1, 10, 10});
      rd(0, m_duty, '1);
      drain(n + 1);
      n = win_idx;
      wr(0, 0);
      winq.push_back('{n + 1, 10, 0});
      drain(n + 1);
      // Inverted polarity, then disable mid-period.
      n = win_idx;
      wr(0, 4);
      wr(2, 3);
      winq.push_back('{n + 1, 10, 6});
      drain(n + 1);
      wr(2, 2);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("dis_pwm", 32'(pwm_out), 32'd1);
         check("dis_tick", 32'(period_tick), 32'd0);
      end
      @(posedge clk);
      #1;
      rd(3, 32'd0, 32'hFFFF_0003);
      rd(2, m_ctrl, '1);
      // PERIOD=0 ticks every cycle; while disabled writes apply immediately.
      wr(1, 0);
      wr(0, 1);
      wr(2, 1);
      rd(1, m_period, '1);
      wait_tick();
      n = win_idx;
      for (int i = 2; i <= 5; i++) winq.push_back('{n + i, 1, 1});
      drain(n + 5);
      wr(0, 0);
      n = win_idx;
      for (int i = 3; i <= 5; i++) winq.push_back('{n + i, 1, 0});
      drain(n + 5);
      wr(2, 0);
      wr(1, 9);
      wr(2, 1);
      // Random duty/period reconfiguration, one update per window.
      for (int it = 0; it < 24; it++) begin
         wait_tick();
         n = win_idx;
         p = int'($urandom_range(4, 24));
         d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 30));
         wr(1, 32'(p));
         wr(0, d);
         ds = sat(d);
         winq.push_back('{n + 1, p + 1, high_count(ds, p + 1)});
         case ($urandom_range(0, 3))
            0: rd(0, m_duty, '1);
            1: rd(1, m_period, '1);
            2: begin
               wr(4 + int'($urandom_range(0, 50)), $urandom);
               rd(0, m_duty, '1);
            end
            default: begin
               wr(-1, $urandom);
               rd(-1, 32'd0, '1);
            end
         endcase
      end
      drain(win_idx + 1);
`ifdef PWM_IRQ_EN
      wr(2, 5);
      wait_tick();
      @(negedge clk);
      check("irq_set", 32'(irq), 32'd1);
      @(posedge clk);
      #1;
      wr(3, 4);
      @(posedge clk);
      #1;
      check("irq_cleared", 32'(irq), 32'd0);
      rd(3, 32'd0, 32'h4);
      wait_tick();
      check("irq_reset_on_wrap", 32'(irq), 32'd1);
      rd(3, 32'h4, 32'h4);
      rd(2, m_ctrl, '1);
`endif
      // Asynchronous reset in the middle of a period.
      wr(0, 32'hFFFF);
      wait_tick();
      wait_tick();
      rd(1, m_period, '1);
      @(negedge clk);
      @(posedge clk);
      #2;
      check("pre_rst_pwm", 32'(pwm_out), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_pwm", 32'(pwm_out), 32'd0);
      check("arst_tick", 32'(period_tick), 32'd0);
      check("arst_rdata", bus.avs_readdata, 32'd0);
      check("arst_rdvalid", 32'(bus.avs_readdatavalid), 32'd0);
`ifdef PWM_IRQ_EN
      check("arst_irq", 32'(irq), 32'd0);
`endif
      m_duty = 0;
      m_period = MAXV;
      m_ctrl = 1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      rd(0, m_duty, '1);
      rd(1, m_period, '1);
      rd(2, m_ctrl, '1);
      rd(3, 32'd0, 32'h0000_0007);
      repeat (3) @(posedge clk);
      check("rdq_drained", 32'(rdq.size()), 32'd0);
      check("winq_drained", 32'(winq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
